fp_mult_apb_master: RTL and testbench
=====================================

FP_MULT_APB_MASTER -- requirements
Module: fp_mult_apb_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of the first multiplier register.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of ACCESS cycles without pready before abort (range 1-255).
REQ-003 pclk  in  1  SHALL be the single clock; all logic rising-edge.
REQ-004 presetn  in  1  SHALL be the reset: synchronous, active-high (1 = reset).
REQ-005 start  in  1  SHALL request one job; sampled only in IDLE.
REQ-006 op_a1, op_b1, op_a2, op_b2  in  32 each  SHALL be the operands; latched on the accepted start.
REQ-007 busy  out  1  SHALL be high from the cycle after an accepted start until the cycle done pulses.
REQ-008 done  out  1  SHALL be a one-cycle pulse at job end (success or abort).
REQ-009 err  out  1  SHALL be valid with done: 1 = timeout abort, 0 = success.
REQ-010 res1, res2  out  32 each  SHALL hold the two read results; valid with done when err=0.
REQ-011 paddr  out  32, psel  out  1, penable  out  1, pwrite  out  1, pwdata  out  32  SHALL be the APB requester outputs, all registered.
REQ-012 pready  in  1, prdata  in  32  SHALL be the APB completer responses.

Function
REQ-013 A job SHALL be six APB transfers in order, index k=0..5: writes op_a1, op_b1, op_a2, op_b2 (k=0..3), then reads res1, res2 (k=4,5).
REQ-014 paddr SHALL be BASE_ADDR + 4*k (32-bit wrap on overflow); pwrite SHALL be 1 for k<4 and 0 for k>=4.
REQ-015 pwdata SHALL carry the latched operand for k; for reads it SHALL be 0.
REQ-016 States SHALL be IDLE, SETUP, ACCESS, FINISH, ABORT.
REQ-017 IDLE: psel=0, penable=0; start=1 -> latch operands, k=0, SETUP.
REQ-018 SETUP (exactly one cycle): psel=1, penable=0, paddr/pwrite/pwdata valid for k -> ACCESS.
REQ-019 ACCESS: psel=1, penable=1, paddr/pwrite/pwdata held stable; wait for pready=1.
REQ-020 ACCESS with pready=1: transfer completes; for k=4/5 prdata SHALL be captured into res1/res2 that edge; k<5 -> k+1, SETUP; k=5 -> FINISH.
REQ-021 Back-to-back transfers SHALL pass through SETUP, so penable SHALL drop to 0 for at least one cycle between transfers.
REQ-022 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; reaching TIMEOUT -> ABORT.
REQ-023 FINISH (one cycle): psel=0, penable=0, done=1, err=0 -> IDLE.
REQ-024 ABORT (one cycle): psel=0, penable=0, done=1, err=1, res1/res2 unchanged from previous values -> IDLE.
REQ-025 Best-case job latency SHALL be 6 transfers x 2 cycles + 1 = 13 cycles from start-accept to done.
REQ-026 start while not IDLE SHALL be ignored (no queueing); start on the done cycle SHALL be ignored; start the cycle after done SHALL be accepted.
REQ-027 Operand input changes after acceptance SHALL not affect the running job.
REQ-028 pready outside ACCESS SHALL be ignored.
REQ-029 err SHALL hold its value until the next done.

Reset
REQ-030 presetn=1 at a rising edge SHALL, regardless of state, force IDLE, k=0, wait counter=0, and outputs busy, done, err, psel, penable, pwrite=0, paddr, pwdata, res1, res2=0.
REQ-031 Reset mid-transfer SHALL drop psel/penable at that edge with no transfer completion or capture.
REQ-032 After presetn returns to 0 the block SHALL accept start on the first following cycle.

Verification
REQ-033 Zero-wait job: BASE_ADDR=0x100, operands 0x3F800000, 0x40000000, 0x40400000, 0x40800000, pready tied 1, prdata 0x40000000 then 0x41400000 -> paddr sequence 0x100..0x114, done at cycle 13, err=0, res1=0x40000000, res2=0x41400000.
REQ-034 Wait states: pready low 3 cycles in transfer k=2 and k=4 -> paddr/pwdata/pwrite stable during waits, done at cycle 19, correct results.
REQ-035 Timeout: TIMEOUT=4, pready stuck 0 at k=1 -> ABORT after 4 ACCESS cycles, done=1 err=1, psel=0, res1/res2 unchanged.
REQ-036 Start during busy and on done cycle -> ignored; start one cycle after done -> new job with freshly latched operands.
REQ-037 Reset asserted in ACCESS of k=4 -> all outputs 0 next edge, no res1 capture; restart completes normally.
REQ-038 Protocol checker on every transfer: SETUP precedes ACCESS, penable only with psel, penable low between transfers.

Source files
------------

// File: rtl/fp_mult_apb_master.sv
// rtl/fp_mult_apb_master.sv - APB requester: writes four operands to a multiplier, reads back two results
// presetn is a synchronous reset that is active HIGH despite its name.
module fp_mult_apb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        start,
   input  logic [31:0] op_a1,
   input  logic [31:0] op_b1,
   input  logic [31:0] op_a2,
   input  logic [31:0] op_b2,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] res1,
   output logic [31:0] res2,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic        pready,
   input  logic [31:0] prdata
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, FINISH, ABORT} state_t;

   state_t            state, state_nx;
   logic [2:0]        k, k_nx;
   logic [7:0]        wait_cnt, wait_cnt_nx;
   logic [3:0][31:0]  ops, ops_nx;
   logic [31:0]       addr_nx;
   logic [31:0]       wdata_nx;

   always_comb begin
      state_nx    = state;
      k_nx        = k;
      wait_cnt_nx = wait_cnt;
      ops_nx      = ops;
      case (state)
         IDLE: begin
            if (start) begin
               ops_nx   = {op_b2, op_a2, op_b1, op_a1};
               k_nx     = 3'd0;
               state_nx = SETUP;
            end
         end
         SETUP: begin
            wait_cnt_nx = 8'd0;
            state_nx    = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               if (k == 3'd5) begin
                  state_nx = FINISH;
               end else begin
                  k_nx     = k + 3'd1;
                  state_nx = SETUP;
               end
            end else if ({24'd0, wait_cnt} + 32'd1 >= TIMEOUT) begin
               state_nx = ABORT;
            end else begin
               wait_cnt_nx = wait_cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bus fields are computed from the next transfer index so they are registered on SETUP entry.
   assign addr_nx  = BASE_ADDR + {27'd0, k_nx, 2'b00};
   assign wdata_nx = (k_nx < 3'd4) ? ops_nx[k_nx[1:0]] : 32'd0;

   always_ff @(posedge pclk) begin
      if (presetn) begin
         state    <= IDLE;
         k        <= 3'd0;
         wait_cnt <= 8'd0;
         ops      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         psel     <= 1'b0;
         penable  <= 1'b0;
         pwrite   <= 1'b0;
         paddr    <= 32'd0;
         pwdata   <= 32'd0;
         res1     <= 32'd0;
         res2     <= 32'd0;
      end else begin
         state    <= state_nx;
         k        <= k_nx;
         wait_cnt <= wait_cnt_nx;
         ops      <= ops_nx;
         psel     <= (state_nx == SETUP) || (state_nx == ACCESS);
         penable  <= (state_nx == ACCESS);
         busy     <= (state_nx == SETUP) || (state_nx == ACCESS);
         done     <= (state_nx == FINISH) || (state_nx == ABORT);
         if (state_nx == FINISH) begin
            err <= 1'b0;
         end else if (state_nx == ABORT) begin
            err <= 1'b1;
         end
         if (state_nx == SETUP) begin
            paddr  <= addr_nx;
            pwrite <= (k_nx < 3'd4);
            pwdata <= wdata_nx;
         end
         if ((state == ACCESS) && pready) begin
            if (k == 3'd4) res1 <= prdata;
            if (k == 3'd5) res2 <= prdata;
         end
      end
   end

endmodule

// File: tb/tb_fp_mult_apb_master.sv
// tb/tb_fp_mult_apb_master.sv - scoreboard bench for fp_mult_apb_master with a programmable-wait APB completer
module tb_fp_mult_apb_master;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int          TO   = 4;

   logic        pclk = 1'b0;
   logic        presetn = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a1 = '0, op_b1 = '0, op_a2 = '0, op_b2 = '0;
   logic        busy, done, err, psel, penable, pwrite, pready;
   logic [31:0] res1, res2, paddr, pwdata, prdata;

   fp_mult_apb_master #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
      .pclk(pclk), .presetn(presetn), .start(start),
      .op_a1(op_a1), .op_b1(op_b1), .op_a2(op_a2), .op_b2(op_b2),
      .busy(busy), .done(done), .err(err), .res1(res1), .res2(res2),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pready(pready), .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   int nvec = 0;
   int nfail = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Completer: need[k] = wait cycles for transfer k, -1 = never ready; pready idles high.
   int          need [6];
   int          wcnt = 0;
   int          kb;
   logic [31:0] rd1 = '0, rd2 = '0;

   always_comb begin
      kb = int'((paddr - BASE) >> 2);
      if (psel && penable) pready = (kb < 6) && (need[kb] >= 0) && (wcnt >= need[kb]);
      else                 pready = 1'b1;
      prdata = (kb == 4) ? rd1 : (kb == 5) ? rd2 : 32'hDEAD_BEEF;
   end

   always @(posedge pclk) wcnt <= (psel && penable && !pready) ? wcnt + 1 : 0;

   typedef struct {
      bit          is_done;
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wdata;
      bit          err;
      logic [31:0] r1;
      logic [31:0] r2;
      int          cyc;
   } exp_t;

   exp_t q[$];

   always @(negedge pclk) begin
      exp_t e;
      if (psel && penable && pready) begin
         if (q.size() == 0) chk("xfer_expected", 0, 1);
         else begin
            e = q.pop_front();
            chk("xfer_kind", 32'(e.is_done), 0);
            chk("paddr", paddr, e.addr);
            chk("pwrite", 32'(pwrite), 32'(e.wr));
            chk("pwdata", pwdata, e.wdata);
         end
      end
      if (done) begin
         if (q.size() == 0) chk("done_expected", 0, 1);
         else begin
            e = q.pop_front();
            chk("done_kind", 32'(e.is_done), 1);
            chk("done_cycle", cyc, e.cyc);
            chk("err", 32'(err), 32'(e.err));
            chk("res1", res1, e.r1);
            chk("res2", res2, e.r2);
            chk("psel_on_done", 32'(psel), 0);
            chk("penable_on_done", 32'(penable), 0);
         end
      end
   end

   // Protocol checker on the registered bus outputs.
   logic        pp_sel = 0, pp_en = 0, pp_rdy = 0, pp_wr = 0, pp_done = 0;
   logic [31:0] pp_addr = '0, pp_wdata = '0;

   always @(negedge pclk) begin
      if (penable) chk("penable_needs_psel", 32'(psel), 1);
      if (penable && !pp_en) chk("setup_before_access", 32'(pp_sel), 1);
      if (pp_en && pp_rdy) chk("penable_low_between", 32'(penable), 0);
      if (penable && pp_en && !pp_rdy) begin
         chk("paddr_stable", paddr, pp_addr);
         chk("pwdata_stable", pwdata, pp_wdata);
         chk("pwrite_stable", 32'(pwrite), 32'(pp_wr));
      end
      if (pp_done) chk("done_one_cycle", 32'(done), 0);
      pp_sel = psel; pp_en = penable; pp_rdy = pready; pp_wr = pwrite;
      pp_done = done; pp_addr = paddr; pp_wdata = pwdata;
   end

   logic [31:0] cur_ops [4];

   task automatic push_xfers(input int nk);
      exp_t e;
      for (int k = 0; k < nk; k++) begin
         e = '{default: 0};
         e.addr  = BASE + 32'(4 * k);
         e.wr    = (k < 4);
         e.wdata = (k < 4) ? cur_ops[k] : 32'd0;
         q.push_back(e);
      end
   endtask

   task automatic push_done(input int c, input bit e_err, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      e = '{default: 0};
      e.is_done = 1'b1;
      e.cyc = c;
      e.err = e_err;
      e.r1 = r1;
      e.r2 = r2;
      q.push_back(e);
   endtask

   task automatic drive_ops;
      op_a1 = cur_ops[0]; op_b1 = cur_ops[1]; op_a2 = cur_ops[2]; op_b2 = cur_ops[3];
   endtask

   task automatic scramble_ops;
      op_a1 = ~cur_ops[0]; op_b1 = ~cur_ops[1]; op_a2 = ~cur_ops[2]; op_b2 = ~cur_ops[3];
   endtask

   task automatic start_job(output int a);
      @(negedge pclk);
      drive_ops();
      start = 1'b1;
      @(posedge pclk);
      #1;
      a = cyc;
      start = 1'b0;
      scramble_ops();
      chk("busy_after_accept", 32'(busy), 1);
   endtask

   task automatic wait_done(input bit poke);
      for (int i = 0; i < 64; i++) begin
         @(negedge pclk);
         if (done) begin
            start = 1'b0;
            return;
         end
         start = poke & i[0];
      end
      start = 1'b0;
      chk("done_within_budget", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_psel"}, 32'(psel), 0);
      chk({tag, "_penable"}, 32'(penable), 0);
      chk({tag, "_pwrite"}, 32'(pwrite), 0);
      chk({tag, "_paddr"}, paddr, 0);
      chk({tag, "_pwdata"}, pwdata, 0);
      chk({tag, "_res1"}, res1, 0);
      chk({tag, "_res2"}, res2, 0);
   endtask

   initial begin
      int a;
      bit hit;
      need = '{0, 0, 0, 0, 0, 0};
      repeat (3) @(posedge pclk);
      #1;
      check_zero("reset");
      presetn = 1'b0;

      // Zero-wait job: 1.0*2.0 = 2.0, 3.0*4.0 = 12.0
      cur_ops = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      rd1 = 32'h4000_0000; rd2 = 32'h4140_0000;
      push_xfers(6);
      start_job(a);
      push_done(a + 12, 1'b0, rd1, rd2);
      wait_done(1'b0);

      // Three wait states on k=2 and k=4: -2.0*0.5 = -1.0, 5.0*-1.0 = -5.0
      cur_ops = '{32'hC000_0000, 32'h3F00_0000, 32'h40A0_0000, 32'hBF80_0000};
      rd1 = 32'hBF80_0000; rd2 = 32'hC0A0_0000;
      need = '{0, 0, 3, 0, 3, 0};
      push_xfers(6);
      start_job(a);
      push_done(a + 18, 1'b0, rd1, rd2);
      wait_done(1'b0);

      // Timeout on k=1: only k=0 completes, results keep the previous job's values
      cur_ops = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      need = '{0, -1, 0, 0, 0, 0};
      push_xfers(1);
      start_job(a);
      push_done(a + 2 + 1 + TO, 1'b1, 32'hBF80_0000, 32'hC0A0_0000);
      wait_done(1'b0);

      // Start pulsed while busy, then again on the done cycle and the cycle after
      cur_ops = '{32'h4100_0000, 32'h3E80_0000, 32'h4120_0000, 32'h4120_0000};
      rd1 = 32'h4000_0000; rd2 = 32'h42C8_0000;
      need = '{0, 0, 0, 0, 0, 0};
      push_xfers(6);
      start_job(a);
      chk("err_held", 32'(err), 1);
      push_done(a + 12, 1'b0, rd1, rd2);
      wait_done(1'b1);
      start = 1'b1;
      op_a1 = 32'hBAD0_0001; op_b1 = 32'hBAD0_0002; op_a2 = 32'hBAD0_0003; op_b2 = 32'hBAD0_0004;
      cur_ops = '{32'h3FC0_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F00_0000};
      rd1 = 32'h4040_0000; rd2 = 32'hBFC0_0000;
      push_xfers(6);
      @(negedge pclk);
      drive_ops();
      @(posedge pclk);
      #1;
      a = cyc;
      start = 1'b0;
      scramble_ops();
      chk("busy_after_done_restart", 32'(busy), 1);
      push_done(a + 12, 1'b0, rd1, rd2);
      wait_done(1'b0);

      // Reset during the ACCESS of k=4 while pready is high: no capture
      cur_ops = '{32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
      rd1 = 32'h3F80_0000; rd2 = 32'h4000_0000;
      push_xfers(5);
      start_job(a);
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (psel && penable && (paddr == BASE + 32'd16)) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reached_k4_access", 32'(hit), 1);
      #2;
      presetn = 1'b1;
      @(posedge pclk);
      #1;
      check_zero("midreset");
      chk("queue_after_reset", q.size(), 0);
      presetn = 1'b0;
      cur_ops = '{32'h4040_0000, 32'h4040_0000, 32'h3F80_0000, 32'hC000_0000};
      rd1 = 32'h4110_0000; rd2 = 32'hC000_0000;
      push_xfers(6);
      drive_ops();
      start = 1'b1;
      @(posedge pclk);
      #1;
      a = cyc;
      start = 1'b0;
      scramble_ops();
      chk("busy_after_reset_start", 32'(busy), 1);
      push_done(a + 12, 1'b0, rd1, rd2);
      wait_done(1'b0);

      repeat (3) @(negedge pclk);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
